// File: rtl/mult_seq_ctrl_if.sv
// Handshake and result bus between a requester and the sequential multiplier.
interface mult_seq_ctrl_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;

  modport master (
    output start, a, b,
    input  busy, done, product_hi, product_lo
  );

  modport slave (
    input  start, a, b,
    output busy, done, product_hi, product_lo
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Unsigned 32x32 shift-add multiplier: one iteration per cycle through a
// single shared 32-bit adder, 64-bit result registered on completion.
module adder_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] s
);
  assign s = x + y;
endmodule

module mult_seq_ctrl (
  input  logic           clk,
  input  logic           rst,
  mult_seq_ctrl_if.slave bus
);
  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(31);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state, state_d;
  logic [OP_W-1:0]   m, m_d;
  logic [PROD_W-1:0] p, p_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [OP_W-1:0]   prod_hi, prod_hi_d;
  logic [OP_W-1:0]   prod_lo, prod_lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [OP_W-1:0]   sum;
  logic              carry;
  logic [PROD_W-1:0] p_step;

  adder_32 u_adder (
    .x (p[63:32]),
    .y (m),
    .s (sum)
  );

  // The adder has no carry-out, so recover it from the operand and sum MSBs.
  assign carry  = (p[63] & m[31]) | ((p[63] | m[31]) & ~sum[31]);
  assign p_step = p[0] ? {carry, sum, p[31:1]} : {1'b0, p[63:1]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      p       <= '0;
      cnt     <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      m       <= m_d;
      p       <= p_d;
      cnt     <= cnt_d;
      prod_hi <= prod_hi_d;
      prod_lo <= prod_lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; busy/done are registered from the next state.
  always_comb begin
    state_d   = state;
    m_d       = m;
    p_d       = p;
    cnt_d     = cnt;
    prod_hi_d = prod_hi;
    prod_lo_d = prod_lo;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          m_d     = bus.a;
          p_d     = {32'h0, bus.b};
          cnt_d   = '0;
        end
      end
      RUN: begin
        p_d = p_step;
        if (cnt == LAST_ITER) begin
          state_d   = DONE;
          prod_hi_d = p_step[63:32];
          prod_lo_d = p_step[31:0];
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.product_hi = prod_hi;
  assign bus.product_lo = prod_lo;
endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and the product width at 64 bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a  input  32  multiplicand, unsigned; captured on the accept edge only.
REQ-006 b  input  32  multiplier, unsigned; captured on the accept edge only.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 product_hi  output  32  upper half of the registered product.
REQ-010 product_lo  output  32  lower half of the registered product.

Function
REQ-011 The block SHALL perform an unsigned shift-add multiply with a single adder_32 instance shared across all iterations; no other adder or multiplier is permitted.
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN when start=1.
- RUN -> DONE after the 32nd iteration.
- DONE -> IDLE unconditionally.
REQ-013 Accept edge (IDLE with start=1):
- M <= a
- P[63:0] <= {32'h0, b}
- iteration count <= 0
REQ-014 Each RUN edge SHALL perform one iteration.
- If P[0]=1: P <= {c, s, P[31:1]}, where s = adder_32(P[63:32], M) and c is the carry-out.
- If P[0]=0: P <= {1'b0, P[63:1]}.
- Count increments by 1.
REQ-015 adder_32 has no carry port, so c SHALL be derived as (x31 & y31) | ((x31 | y31) & ~s31), where x and y are the adder inputs and s is the adder output.
REQ-016 The transition from RUN to DONE SHALL occur on the edge that completes iteration 32 (count reaches 31 before that edge); the count SHALL NOT wrap or run further.
REQ-017 On the RUN->DONE edge, product_hi/product_lo SHALL be loaded from P[63:32]/P[31:0].
REQ-018 done SHALL be 1 only while in DONE, giving exactly one cycle per operation.
REQ-019 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E32, i.e. 33 cycles after acceptance.
REQ-020 product_hi/product_lo SHALL hold their value until the next RUN->DONE edge.
REQ-021 Starting a new operation SHALL NOT clear the previous product.
REQ-022 start SHALL be ignored in RUN and in DONE; there is no queueing, and a/b changes while busy have no effect.
REQ-023 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-024 start held high continuously SHALL yield back-to-back operations, with each accepted in the IDLE cycle following DONE.
REQ-025 The result SHALL equal a*b mod 2^64 exactly; overflow cannot occur.

Reset
REQ-026 On rst=1 at any edge, the block SHALL enter IDLE and clear:
- busy=0, done=0
- product_hi=0, product_lo=0
- M, P, count = 0
REQ-027 rst SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.
REQ-028 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-029 Basic multiply: a=3, b=5, start for one cycle -> busy=1 for 33 cycles, then done=1 for exactly one cycle with product_hi=0 and product_lo=15.
REQ-030 Maximum operands: a=b=32'hFFFFFFFF -> product_hi=32'hFFFFFFFE, product_lo=32'h00000001; this exercises the carry on every iteration.
REQ-031 Zero and shift cases:
- a=0, b=32'h12345678 -> product=0.
- a=32'h80000000, b=2 -> product_hi=1, product_lo=0.
REQ-032 Start while busy: start pulsed at cycle 10 of RUN with different a/b -> it SHALL be ignored, the original product SHALL be delivered, and only one done pulse SHALL occur.
REQ-033 Reset mid-operation: rst at cycle 15 of RUN -> the next cycle shows busy=0, done=0 and product=0, with no done pulse; a following start completes normally.
REQ-034 Continuous start with a=7 and b=6 -> done pulses every 34 cycles; product=42 each time, and it SHALL persist between pulses.
